// File: rtl/width_12to8_if.sv
// Handshake bundle for the 12-bit to 8-bit stream converter: word input side,
// flush request and byte output side.
interface width_12to8_if;
    localparam int unsigned IN_W  = 12;
    localparam int unsigned OUT_W = 8;

    logic             valid_in;
    logic             ready_in;
    logic [IN_W-1:0]  data_in;
    logic             flush_in;
    logic             valid_out;
    logic             ready_out;
    logic [OUT_W-1:0] data_out;

    modport slave (
        input  valid_in,
        input  data_in,
        input  flush_in,
        input  ready_out,
        output ready_in,
        output valid_out,
        output data_out
    );

    modport master (
        output valid_in,
        output data_in,
        output flush_in,
        output ready_out,
        input  ready_in,
        input  valid_out,
        input  data_out
    );
endinterface

// File: rtl/width_12to8.sv
// Packs 12-bit words into an MSB-first 8-bit byte stream through a 6-nibble
// left-aligned buffer; a flush pads an odd trailing nibble out to a full byte.
module width_12to8 #(
    parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
    input  logic          clk,
    input  logic          rst,
    width_12to8_if.slave  bus,
    output logic          busy
);
    localparam int unsigned BUF_W = 24;
    localparam int unsigned CNT_W = 3;

    logic [BUF_W-1:0] nib_buf, nib_buf_nxt, popped;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_pop;
    logic             flush_pend, flush_pend_nxt;
    logic             push, pop, pad;

    // Outputs are decoded from registered state only.
    assign bus.ready_in  = (cnt <= CNT_W'(3)) && !flush_pend;
    assign bus.valid_out = (cnt >= CNT_W'(2));
    assign bus.data_out  = bus.valid_out ? nib_buf[BUF_W-1 -: 8] : 8'h00;
    assign busy          = (cnt != '0) || flush_pend;

    assign push = bus.valid_in && bus.ready_in;
    assign pop  = bus.valid_out && bus.ready_out;
    assign pad  = flush_pend && (cnt == CNT_W'(1));

    // Pop shifts first; a push then lands right after the surviving nibbles.
    // Unused slots are kept zero so a push can simply OR into place.
    always_comb begin
        popped         = pop ? {nib_buf[BUF_W-9:0], 8'h00} : nib_buf;
        cnt_pop        = pop ? cnt - CNT_W'(2) : cnt;
        nib_buf_nxt    = popped;
        cnt_nxt        = cnt_pop;
        flush_pend_nxt = 1'b0;

        if (pad) begin
            nib_buf_nxt[BUF_W-5 -: 4] = PAD_NIBBLE;
            cnt_nxt                   = CNT_W'(2);
        end else if (push) begin
            nib_buf_nxt = popped | (BUF_W'({bus.data_in, 12'h000}) >> {cnt_pop, 2'b00});
            cnt_nxt     = cnt_pop + CNT_W'(3);
        end

        // A flush only latches if something is left to drain after this cycle.
        flush_pend_nxt = (flush_pend || bus.flush_in) && (cnt_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nib_buf    <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            nib_buf    <= nib_buf_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end
endmodule

// File: tb/tb_width_12to8.sv
// Self-checking bench for width_12to8: nibble-queue reference model compared
// every cycle, plus directed byte-stream expectations.
module tb_width_12to8;
    localparam logic [3:0] PAD = 4'h0;

    logic clk;
    logic rst;
    logic busy;

    width_12to8_if bus ();

    width_12to8 #(.PAD_NIBBLE(PAD)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 0;

    logic [3:0] q[$];    // model: nibbles waiting to be sent, oldest first
    bit         fp = 0;  // model: flush pending
    logic [7:0] mq[$];   // bytes the model says were popped
    logic [7:0] rx[$];   // bytes the DUT actually handed over

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: advance the nibble queue on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            fp = 0;
            chk_en = 1;
        end else if (chk_en) begin
            int  n;
            bit  m_rdy, m_vld, m_pad;
            n     = q.size();
            m_rdy = (n <= 3) && !fp;
            m_vld = (n >= 2);
            m_pad = fp && (n == 1);
            if (m_vld && bus.ready_out) begin
                mq.push_back({q[0], q[1]});
                void'(q.pop_front());
                void'(q.pop_front());
            end
            if (bus.valid_in && m_rdy) begin
                q.push_back(bus.data_in[11:8]);
                q.push_back(bus.data_in[7:4]);
                q.push_back(bus.data_in[3:0]);
            end
            if (m_pad) q.push_back(PAD);
            if (q.size() == 0) fp = 0;
            else if (bus.flush_in) fp = 1;
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            logic [7:0] e_data;
            bit         e_vld;
            e_vld  = (q.size() >= 2);
            e_data = e_vld ? {q[0], q[1]} : 8'h00;
            check("valid_out", 32'(bus.valid_out), 32'(e_vld));
            check("data_out",  32'(bus.data_out),  32'(e_data));
            check("ready_in",  32'(bus.ready_in),  32'((q.size() <= 3) && !fp));
            check("busy",      32'(busy),          32'((q.size() != 0) || fp));
            if (bus.valid_out && bus.ready_out) rx.push_back(bus.data_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [11:0] w);
        bit done;
        done = 0;
        bus.valid_in = 1'b1;
        bus.data_in  = w;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (bus.ready_in) done = 1;
            @(posedge clk);
            #1;
        end
        bus.valid_in = 1'b0;
        check("push_timeout", 32'(done), 32'd1);
    endtask

    task automatic flush_pulse();
        bus.flush_in = 1'b1;
        step();
        bus.flush_in = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        check("idle_timeout", 32'(done), 32'd1);
        step();
    endtask

    task automatic check_rx(input string name, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] e[3];
        e[0] = b0; e[1] = b1; e[2] = b2;
        check({name, "_count"}, 32'(rx.size()), 32'(n));
        for (int i = 0; i < n && i < rx.size(); i++)
            check({name, "_byte"}, 32'(rx[i]), 32'(e[i]));
    endtask

    initial begin
        logic [11:0] words[8];
        int          idx;
        bit          acc;

        clk = 0;
        rst = 1;
        bus.valid_in  = 0;
        bus.data_in   = '0;
        bus.flush_in  = 0;
        bus.ready_out = 0;
        repeat (2) step();
        rst = 0;
        @(negedge clk);
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_data_out",  32'(bus.data_out),  32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_ready_in",  32'(bus.ready_in),  32'd1);
        step();

        // Basic order
        bus.ready_out = 1;
        rx.delete(); mq.delete();
        push_word(12'hABC);
        push_word(12'hDEF);
        wait_idle();
        check_rx("basic", 3, 8'hAB, 8'hCD, 8'hEF);
        check("basic_model_n", 32'(mq.size()), 32'd3);
        if (mq.size() == 3) check("basic_model_b1", 32'(mq[1]), 32'hCD);
        check("basic_busy", 32'(busy), 32'd0);

        // Backpressure
        bus.ready_out = 0;
        rx.delete();
        push_word(12'h123);
        push_word(12'h456);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_data",  32'(bus.data_out),  32'h12);
            check("bp_hold_valid", 32'(bus.valid_out), 32'd1);
            check("bp_ready_in",   32'(bus.ready_in),  32'd0);
        end
        step();
        bus.ready_out = 1;
        wait_idle();
        check_rx("bp", 3, 8'h12, 8'h34, 8'h56);

        // Flush with an odd trailing nibble
        rx.delete();
        push_word(12'h123);
        flush_pulse();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy) break;
            check("flush_ready_in", 32'(bus.ready_in), 32'd0);
        end
        step();
        check_rx("flush_odd", 2, 8'h12, 8'h30, 8'h00);

        // Flush while idle
        rx.delete();
        flush_pulse();
        repeat (2) step();
        check("flush_idle_busy", 32'(busy), 32'd0);
        check("flush_idle_rx",   32'(rx.size()), 32'd0);

        // Flush after an even pair of words
        push_word(12'h9A7);
        push_word(12'h3C1);
        flush_pulse();
        wait_idle();
        check_rx("flush_even", 3, 8'h9A, 8'h73, 8'hC1);

        // Streaming with random valid/ready
        rx.delete();
        for (int i = 0; i < 8; i++) words[i] = 12'($urandom);
        idx = 0;
        for (int cyc = 0; cyc < 2000 && idx < 8; cyc++) begin
            bus.valid_in  = 1'($urandom % 2);
            bus.data_in   = words[idx];
            bus.ready_out = 1'($urandom % 2);
            @(negedge clk);
            acc = bus.valid_in && bus.ready_in;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        bus.valid_in = 0;
        check("stream_words", 32'(idx), 32'd8);
        bus.ready_out = 1;
        wait_idle();
        check("stream_count", 32'(rx.size()), 32'd12);
        for (int k = 0; k < 4; k++) begin
            logic [11:0] w0, w1;
            w0 = words[2*k];
            w1 = words[2*k+1];
            if (rx.size() == 12) begin
                check("stream_b0", 32'(rx[3*k]),   32'(w0[11:4]));
                check("stream_b1", 32'(rx[3*k+1]), 32'({w0[3:0], w1[11:8]}));
                check("stream_b2", 32'(rx[3*k+2]), 32'(w1[7:0]));
            end
        end

        // Random traffic including flushes, checked cycle by cycle
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.valid_in  = 1'($urandom % 2);
            bus.data_in   = 12'($urandom);
            bus.ready_out = 1'(($urandom % 4) != 0);
            bus.flush_in  = 1'(($urandom % 12) == 0);
            step();
        end
        bus.valid_in = 0;
        bus.ready_out = 1;
        flush_pulse();
        wait_idle();

        // Reset mid-stream
        rx.delete();
        push_word(12'hFED);
        step();
        check_rx("rst_pre", 1, 8'hFE, 8'h00, 8'h00);
        rx.delete();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        check("midrst_valid_out", 32'(bus.valid_out), 32'd0);
        check("midrst_data_out",  32'(bus.data_out),  32'd0);
        check("midrst_ready_in",  32'(bus.ready_in),  32'd1);
        step();
        push_word(12'h0A5);
        repeat (3) step();
        check_rx("rst_post", 1, 8'h0A, 8'h00, 8'h00);
        flush_pulse();
        wait_idle();
        check_rx("rst_flush", 2, 8'h0A, 8'h50, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/width_12to8.md
Name: width_12to8

Overview:
- Converts a stream of 12-bit words into a stream of 8-bit bytes, MSB-first, with no gaps or padding between words. Two input words always yield exactly three bytes.
- Sits on the transmit side of the 8-to-12 packing path and is the inverse of the 8-to-12 converter.
- Valid/ready handshakes on both sides.
- A flush request drains a trailing half-byte by padding it to a full byte.

Parameters:
- PAD_NIBBLE, 4'h0: value appended as the low nibble of the final byte when a flush finds an odd residual nibble.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in holds a valid 12-bit word.
- ready_in  output  1  converter can accept a word this cycle.
- data_in  input  12  input word; bit 11 is sent first.
- flush_in  input  1  single-cycle request to pad and drain an odd trailing nibble.
- valid_out  output  1  data_out holds a valid byte.
- ready_out  input  1  downstream accepts the byte this cycle.
- data_out  output  8  output byte.
- busy  output  1  buffer non-empty or flush pending.

Behaviour:
- Clocking and reset
  - Single clock clk. Reset rst is synchronous and active-high.
  - rst=1 at a rising edge clears buf, cnt and flush_pend. All other inputs are ignored that cycle.
  - Reset values: valid_out=0, data_out=8'h00, busy=0. ready_in=1 from the first cycle after reset.
  - Reset mid-operation discards buffered nibbles and any pending flush. No partial byte is emitted afterwards.
- State
  - buf: 24-bit left-aligned nibble buffer; buf[23:20] is the oldest nibble.
  - cnt: valid-nibble count, 3 bits, range 0..6.
  - flush_pend: 1-bit flag.
- Events per cycle
  - push = valid_in & ready_in.
  - pop = valid_out & ready_out.
  - pad = flush_pend & (cnt==1).
- Outputs
  - ready_in = (cnt <= 3) & ~flush_pend. It depends only on registered state; there is no combinational path from ready_out or valid_in.
  - valid_out = (cnt >= 2).
  - data_out = buf[23:16], and is 8'h00 whenever cnt < 2.
  - busy = (cnt != 0) | flush_pend.
- Update order within a cycle
  - If pop: shift buf left 8, zero-fill, cnt -= 2.
  - If push: write data_in into the 3 nibble slots starting at post-pop position cnt', cnt' += 3.
  - push and pop in the same cycle are legal: next cnt = cnt - 2*pop + 3*push, max 6.
- Byte order for words W0, W1
  - Byte 0 = W0[11:4].
  - Byte 1 = {W0[3:0], W1[11:8]}.
  - Byte 2 = W1[7:0].
- Flush
  - flush_in=1 with cnt==0 and flush_pend==0 has no effect.
  - Otherwise flush_in sets flush_pend. flush_in while flush_pend=1 is ignored.
  - While flush_pend=1, ready_in=0 and bytes continue to drain normally.
  - pad (cnt==1): write PAD_NIBBLE into slot 1, cnt=2. No pop is possible that cycle.
  - flush_pend clears in the cycle cnt becomes 0.
  - A push and a flush_in in the same cycle: the push is accepted first, then flush_pend is set.
- Valid/ready rules
  - Once valid_out=1, data_out holds stable until popped.
  - valid_in with ready_in=0 is not consumed; upstream must hold the word.
- Throughput: with ready_out held high and valid_in always high, steady state is 1 byte/cycle out and 2 words per 3 cycles in.

Test Plan:
- Basic order: push 12'hABC, 12'hDEF back-to-back, ready_out=1 -> bytes 8'hAB, 8'hCD, 8'hEF in order; busy=0 after the last pop.
- Backpressure: ready_out=0, push 12'h123, 12'h456 -> second push accepted (cnt 3->6), then ready_in=0; valid_out=1 with data_out=8'h12 held stable 10 cycles. Release ready_out -> 8'h12, 8'h34, 8'h56.
- Flush odd: push 12'h123, flush_in pulse, ready_out=1 -> bytes 8'h12, 8'h30 (PAD_NIBBLE=0); ready_in=0 until busy drops.
- Flush even or idle: flush_in with cnt==0 -> no output, busy stays 0. Flush after 2 words -> exactly 3 bytes, no pad byte.
- Streaming: 8 random words, valid_in and ready_out randomly toggled -> 12 bytes matching the reference packing model; cnt never exceeds 6.
- Reset mid-stream: push 12'hFED, pop 8'hFE, assert rst -> valid_out=0, data_out=8'h00, ready_in=1 next cycle. Then push 12'h0A5 -> 8'h0A first, so the stale nibble D is never emitted.
